// File: rtl/conveyor_bank.sv
// Multi-context circular result conveyor: one ring per context with immediate pushes,
// reserved slots filled later by completion ports, and interrupt-service double pushes.
module conveyor_bank #(
    parameter int unsigned WORD_WIDTH          = 32,
    parameter int unsigned CONVEYOR_ADDR_WIDTH = 4,
    parameter int unsigned CONTEXTS            = 2,
    parameter int unsigned PRODUCERS           = 2,
    parameter int unsigned FAULT_ADDR_WIDTH    = 3,
    parameter int unsigned CTX_WIDTH           = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic [CTX_WIDTH-1:0]                     i_context,
    input  logic                                     i_read_en,
    input  logic [CONVEYOR_ADDR_WIDTH-1:0]           i_read_offset,
    output logic [WORD_WIDTH-1:0]                    o_read_value,
    output logic                                     o_halt,
    output logic [FAULT_ADDR_WIDTH-1:0]              o_fault,
    input  logic                                     i_push,
    input  logic [WORD_WIDTH-1:0]                    i_push_value,
    input  logic                                     i_reserve,
    output logic [CONVEYOR_ADDR_WIDTH-1:0]           o_reserve_slot,
    output logic                                     o_push_stall,
    input  logic                                     i_svc,
    input  logic [CTX_WIDTH-1:0]                     i_svc_context,
    input  logic [WORD_WIDTH-1:0]                    i_svc_value,
    input  logic [WORD_WIDTH-1:0]                    i_svc_bus,
    input  logic [PRODUCERS-1:0]                     i_complete_valid,
    input  logic [PRODUCERS*CTX_WIDTH-1:0]           i_complete_context,
    input  logic [PRODUCERS*CONVEYOR_ADDR_WIDTH-1:0] i_complete_slot,
    input  logic [PRODUCERS*FAULT_ADDR_WIDTH-1:0]    i_complete_fault,
    input  logic [PRODUCERS*WORD_WIDTH-1:0]          i_complete_value,
    output logic [CONTEXTS-1:0]                      o_pending_any,
    output logic                                     o_collision
);
    localparam int unsigned DEPTH = 2 ** CONVEYOR_ADDR_WIDTH;
    localparam int unsigned AW    = CONVEYOR_ADDR_WIDTH;

    logic [AW-1:0]               r_head  [CONTEXTS];
    logic [DEPTH-1:0]            r_fin   [CONTEXTS];
    logic [DEPTH-1:0]            r_pend  [CONTEXTS];
    logic [FAULT_ADDR_WIDTH-1:0] r_fault [CONTEXTS][DEPTH];
    logic [WORD_WIDTH-1:0]       r_value [CONTEXTS][DEPTH];
    logic                        r_collision;

    logic [AW-1:0]               w_head_d  [CONTEXTS];
    logic [DEPTH-1:0]            w_fin_d   [CONTEXTS];
    logic [DEPTH-1:0]            w_pend_d  [CONTEXTS];
    logic [FAULT_ADDR_WIDTH-1:0] w_fault_d [CONTEXTS][DEPTH];
    logic [WORD_WIDTH-1:0]       w_value_d [CONTEXTS][DEPTH];
    logic                        w_collision_d;

    logic [AW-1:0]        w_rd_slot;
    logic [AW-1:0]        w_pr_slot;
    logic [AW-1:0]        w_svc_s1;
    logic [AW-1:0]        w_svc_s2;
    logic                 w_pr_do;
    logic                 w_drop;
    logic [CTX_WIDTH-1:0] w_cp_ctx;
    logic [AW-1:0]        w_cp_slot;

    assign w_rd_slot      = r_head[i_context] + i_read_offset;
    assign w_pr_slot      = r_head[i_context] - AW'(1);
    assign w_svc_s1       = r_head[i_svc_context] - AW'(1);
    assign w_svc_s2       = r_head[i_svc_context] - AW'(2);
    assign o_push_stall   = (i_push | i_reserve) & i_svc & (i_svc_context == i_context);
    assign w_pr_do        = (i_push | i_reserve) & ~o_push_stall;
    assign o_reserve_slot = w_pr_slot;
    assign o_read_value   = r_value[i_context][w_rd_slot];
    assign o_halt         = i_read_en & ~r_fin[i_context][w_rd_slot];
    assign o_fault        = (i_read_en & r_fin[i_context][w_rd_slot]) ?
                            r_fault[i_context][w_rd_slot] : '0;
    assign o_collision    = r_collision;

    always_comb begin
        o_pending_any = '0;
        for (int c = 0; c < CONTEXTS; c++) o_pending_any[c] = |r_pend[c];
    end

    always_comb begin
        w_head_d      = r_head;
        w_fin_d       = r_fin;
        w_pend_d      = r_pend;
        w_fault_d     = r_fault;
        w_value_d     = r_value;
        w_collision_d = 1'b0;
        w_drop        = 1'b0;
        w_cp_ctx      = '0;
        w_cp_slot     = '0;

        // Ring wrapped onto an outstanding result: the write still proceeds.
        if (i_svc && (r_pend[i_svc_context][w_svc_s1] || r_pend[i_svc_context][w_svc_s2]))
            w_collision_d = 1'b1;
        if (w_pr_do && r_pend[i_context][w_pr_slot])
            w_collision_d = 1'b1;

        for (int p = 0; p < PRODUCERS; p++) begin
            if (i_complete_valid[p]) begin
                w_cp_ctx  = i_complete_context[p*CTX_WIDTH +: CTX_WIDTH];
                w_cp_slot = i_complete_slot[p*AW +: AW];
                w_drop    = ~r_pend[w_cp_ctx][w_cp_slot];
                for (int q = 0; q < p; q++) begin
                    if (i_complete_valid[q] &&
                        i_complete_context[q*CTX_WIDTH +: CTX_WIDTH] == w_cp_ctx &&
                        i_complete_slot[q*AW +: AW] == w_cp_slot)
                        w_drop = 1'b1;
                end
                if (w_pr_do && w_cp_ctx == i_context && w_cp_slot == w_pr_slot)
                    w_drop = 1'b1;
                if (i_svc && w_cp_ctx == i_svc_context &&
                    (w_cp_slot == w_svc_s1 || w_cp_slot == w_svc_s2))
                    w_drop = 1'b1;
                if (w_drop) begin
                    w_collision_d = 1'b1;
                end else begin
                    w_fin_d[w_cp_ctx][w_cp_slot]   = 1'b1;
                    w_pend_d[w_cp_ctx][w_cp_slot]  = 1'b0;
                    w_fault_d[w_cp_ctx][w_cp_slot] = i_complete_fault[p*FAULT_ADDR_WIDTH +:
                                                                      FAULT_ADDR_WIDTH];
                    w_value_d[w_cp_ctx][w_cp_slot] = i_complete_value[p*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end

        if (i_svc) begin
            w_fin_d[i_svc_context][w_svc_s1]   = 1'b1;
            w_pend_d[i_svc_context][w_svc_s1]  = 1'b0;
            w_fault_d[i_svc_context][w_svc_s1] = '0;
            w_value_d[i_svc_context][w_svc_s1] = i_svc_value;
            w_fin_d[i_svc_context][w_svc_s2]   = 1'b1;
            w_pend_d[i_svc_context][w_svc_s2]  = 1'b0;
            w_fault_d[i_svc_context][w_svc_s2] = '0;
            w_value_d[i_svc_context][w_svc_s2] = i_svc_bus;
            w_head_d[i_svc_context]            = w_svc_s2;
        end

        // Only reached for a context distinct from the svc target.
        if (w_pr_do) begin
            w_fault_d[i_context][w_pr_slot] = '0;
            if (i_push) begin
                w_fin_d[i_context][w_pr_slot]   = 1'b1;
                w_pend_d[i_context][w_pr_slot]  = 1'b0;
                w_value_d[i_context][w_pr_slot] = i_push_value;
            end else begin
                w_fin_d[i_context][w_pr_slot]  = 1'b0;
                w_pend_d[i_context][w_pr_slot] = 1'b1;
            end
            w_head_d[i_context] = w_pr_slot;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < CONTEXTS; c++) begin
                r_head[c] <= '0;
                r_fin[c]  <= '0;
                r_pend[c] <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    r_fault[c][s] <= '0;
                    r_value[c][s] <= '0;
                end
            end
            r_collision <= 1'b0;
        end else begin
            r_head      <= w_head_d;
            r_fin       <= w_fin_d;
            r_pend      <= w_pend_d;
            r_fault     <= w_fault_d;
            r_value     <= w_value_d;
            r_collision <= w_collision_d;
        end
    end
endmodule

// File: tb/tb_conveyor_bank.sv
// Self-checking bench for conveyor_bank: directed scenarios plus randomized traffic
// compared against a slot-array reference model.
module tb_conveyor_bank;
    localparam int W = 32, N = 4, C = 2, P = 2, F = 3, CW = 1, D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CW-1:0]  ctx, svc_ctx;
    logic           read_en, push, reserve, svc;
    logic [N-1:0]   read_offset;
    logic [W-1:0]   push_value, svc_value, svc_bus;
    logic [P-1:0]   cv;
    logic [P*CW-1:0] cctx;
    logic [P*N-1:0] cslot;
    logic [P*F-1:0] cfault;
    logic [P*W-1:0] cval;
    logic [W-1:0]   read_value;
    logic           halt, push_stall, collision;
    logic [F-1:0]   fault;
    logic [N-1:0]   reserve_slot;
    logic [C-1:0]   pending_any;

    conveyor_bank dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_context(ctx), .i_read_en(read_en),
        .i_read_offset(read_offset), .o_read_value(read_value), .o_halt(halt),
        .o_fault(fault), .i_push(push), .i_push_value(push_value), .i_reserve(reserve),
        .o_reserve_slot(reserve_slot), .o_push_stall(push_stall), .i_svc(svc),
        .i_svc_context(svc_ctx), .i_svc_value(svc_value), .i_svc_bus(svc_bus),
        .i_complete_valid(cv), .i_complete_context(cctx), .i_complete_slot(cslot),
        .i_complete_fault(cfault), .i_complete_value(cval), .o_pending_any(pending_any),
        .o_collision(collision)
    );

    typedef struct packed {
        bit         fin;
        bit         pend;
        bit [F-1:0] flt;
        bit [W-1:0] val;
    } mslot_t;

    mslot_t   m  [C][D];
    bit [N-1:0] mh [C];
    bit       m_coll;
    int       n_cmp = 0;
    int       n_err = 0;

    function automatic void model_reset();
        for (int c = 0; c < C; c++) begin
            mh[c] = '0;
            for (int s = 0; s < D; s++) m[c][s] = '0;
        end
        m_coll = 1'b0;
    endfunction

    // Applies one clock edge worth of the behavioural rules to the model.
    task automatic model_apply();
        mslot_t nm [C][D];
        bit [N-1:0] nh [C];
        bit coll, stall, pr_do, drop;
        int wc[3];
        int ws[3];
        int wn, cc, cs;
        bit [N-1:0] s1, s2, ps;
        nm = m; nh = mh; coll = 0; wn = 0;
        stall = (push || reserve) && svc && (svc_ctx == ctx);
        pr_do = (push || reserve) && !stall;
        s1 = mh[svc_ctx] - 4'd1;
        s2 = mh[svc_ctx] - 4'd2;
        ps = mh[ctx] - 4'd1;
        if (svc) begin
            wc[0] = int'(svc_ctx); ws[0] = int'(s1);
            wc[1] = int'(svc_ctx); ws[1] = int'(s2);
            wn = 2;
        end
        if (pr_do) begin
            wc[wn] = int'(ctx); ws[wn] = int'(ps); wn++;
        end
        for (int i = 0; i < wn; i++) if (m[wc[i]][ws[i]].pend) coll = 1;
        for (int p = 0; p < P; p++) begin
            if (cv[p]) begin
                cc = int'(cctx[p*CW +: CW]);
                cs = int'(cslot[p*N +: N]);
                drop = !m[cc][cs].pend;
                for (int q = 0; q < p; q++)
                    if (cv[q] && int'(cctx[q*CW +: CW]) == cc && int'(cslot[q*N +: N]) == cs)
                        drop = 1;
                for (int i = 0; i < wn; i++) if (wc[i] == cc && ws[i] == cs) drop = 1;
                if (drop) coll = 1;
                else nm[cc][cs] = '{fin: 1'b1, pend: 1'b0, flt: cfault[p*F +: F],
                                    val: cval[p*W +: W]};
            end
        end
        if (svc) begin
            nm[svc_ctx][s1] = '{fin: 1'b1, pend: 1'b0, flt: '0, val: svc_value};
            nm[svc_ctx][s2] = '{fin: 1'b1, pend: 1'b0, flt: '0, val: svc_bus};
            nh[svc_ctx] = s2;
        end
        if (pr_do) begin
            if (push) nm[ctx][ps] = '{fin: 1'b1, pend: 1'b0, flt: '0, val: push_value};
            else begin
                nm[ctx][ps].fin  = 1'b0;
                nm[ctx][ps].pend = 1'b1;
                nm[ctx][ps].flt  = '0;
            end
            nh[ctx] = ps;
        end
        m = nm; mh = nh; m_coll = coll;
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ctx = '0; svc_ctx = '0; read_en = 0; push = 0; reserve = 0; svc = 0;
        read_offset = '0; push_value = '0; svc_value = '0; svc_bus = '0;
        cv = '0; cctx = '0; cslot = '0; cfault = '0; cval = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        read_en = 1;
        #1;
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL reset_halt got %0b want 1", halt); end
        n_cmp++; if (fault !== 3'd0) begin n_err++; $display("FAIL reset_fault got %0d want 0", fault); end
        n_cmp++; if (read_value !== 32'h0) begin n_err++; $display("FAIL reset_value got %0h want 0", read_value); end
        n_cmp++; if (pending_any !== 2'b00) begin n_err++; $display("FAIL reset_pend got %0b want 0", pending_any); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL reset_coll got %0b want 0", collision); end
        n_cmp++; if (reserve_slot !== 4'd15) begin n_err++; $display("FAIL reset_rslot got %0d want 15", reserve_slot); end
        apply_reset();
    endtask

    task automatic test_push_read();
        idle(); push = 1; push_value = 32'hA5A5A5A5;
        tick();
        idle(); read_en = 1; read_offset = 0;
        #1;
        n_cmp++; if (read_value !== 32'hA5A5A5A5) begin n_err++; $display("FAIL push_value got %0h want a5a5a5a5", read_value); end
        n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL push_halt got %0b want 0", halt); end
        n_cmp++; if (fault !== 3'd0) begin n_err++; $display("FAIL push_fault got %0d want 0", fault); end
        n_cmp++; if (reserve_slot !== 4'd14) begin n_err++; $display("FAIL push_head got rslot %0d want 14", reserve_slot); end
    endtask

    task automatic test_reserve_complete();
        apply_reset();
        reserve = 1;
        #1;
        n_cmp++; if (reserve_slot !== 4'd15) begin n_err++; $display("FAIL rsv_slot got %0d want 15", reserve_slot); end
        tick();
        idle(); read_en = 1;
        #1;
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL rsv_halt got %0b want 1", halt); end
        n_cmp++; if (pending_any !== 2'b01) begin n_err++; $display("FAIL rsv_pend got %0b want 01", pending_any); end
        cv = 2'b10; cctx[1] = 1'b0; cslot[7:4] = 4'd15; cfault[5:3] = 3'd2; cval[63:32] = 32'h1234;
        tick();
        cv = '0;
        #1;
        n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL cmp_halt got %0b want 0", halt); end
        n_cmp++; if (fault !== 3'd2) begin n_err++; $display("FAIL cmp_fault got %0d want 2", fault); end
        n_cmp++; if (read_value !== 32'h1234) begin n_err++; $display("FAIL cmp_value got %0h want 1234", read_value); end
        n_cmp++; if (pending_any !== 2'b00) begin n_err++; $display("FAIL cmp_pend got %0b want 00", pending_any); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL cmp_coll got %0b want 0", collision); end
    endtask

    task automatic test_svc_cross();
        idle(); ctx = 1; push = 1; push_value = 32'h77;
        svc = 1; svc_ctx = 0; svc_value = 32'h11; svc_bus = 32'h22;
        #1;
        n_cmp++; if (push_stall !== 1'b0) begin n_err++; $display("FAIL xsvc_stall got %0b want 0", push_stall); end
        tick();
        idle(); read_en = 1; ctx = 0; read_offset = 0;
        #1;
        n_cmp++; if (read_value !== 32'h22) begin n_err++; $display("FAIL xsvc_off0 got %0h want 22", read_value); end
        read_offset = 1;
        #1;
        n_cmp++; if (read_value !== 32'h11) begin n_err++; $display("FAIL xsvc_off1 got %0h want 11", read_value); end
        ctx = 1; read_offset = 0;
        #1;
        n_cmp++; if (read_value !== 32'h77) begin n_err++; $display("FAIL xsvc_push got %0h want 77", read_value); end
    endtask

    task automatic test_svc_same();
        idle(); push = 1; push_value = 32'h99;
        svc = 1; svc_value = 32'h33; svc_bus = 32'h44;
        #1;
        n_cmp++; if (push_stall !== 1'b1) begin n_err++; $display("FAIL ssvc_stall got %0b want 1", push_stall); end
        tick();
        idle(); read_en = 1;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] exp_v;
            exp_v = (i == 0) ? 32'h44 : (i == 1) ? 32'h33 : 32'h22;
            read_offset = 4'(i);
            #1;
            n_cmp++;
            if (read_value !== exp_v) begin
                n_err++; $display("FAIL ssvc_off%0d got %0h want %0h", i, read_value, exp_v);
            end
        end
        idle(); push = 1; push_value = 32'h99;
        #1;
        n_cmp++; if (push_stall !== 1'b0) begin n_err++; $display("FAIL retry_stall got %0b want 0", push_stall); end
        tick();
        idle(); read_en = 1;
        #1;
        n_cmp++; if (read_value !== 32'h99) begin n_err++; $display("FAIL retry_value got %0h want 99", read_value); end
    endtask

    task automatic test_dual_complete();
        bit [N-1:0] s;
        idle(); reserve = 1;
        s = mh[0] - 4'd1;
        tick();
        idle();
        cv = 2'b11; cslot = {s, s}; cfault = {3'd5, 3'd1}; cval = {32'hBB, 32'hAA};
        tick();
        idle(); read_en = 1;
        #1;
        n_cmp++; if (read_value !== 32'hAA) begin n_err++; $display("FAIL dual_value got %0h want aa", read_value); end
        n_cmp++; if (fault !== 3'd1) begin n_err++; $display("FAIL dual_fault got %0d want 1", fault); end
        n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL dual_coll got %0b want 1", collision); end
        tick();
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL dual_pulse got %0b want 0", collision); end
        cv = 2'b01; cslot = {4'd0, s}; cval = {32'h0, 32'hCC};
        tick();
        cv = '0;
        #1;
        n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL nonpend_coll got %0b want 1", collision); end
        n_cmp++; if (read_value !== 32'hAA) begin n_err++; $display("FAIL nonpend_value got %0h want aa", read_value); end
    endtask

    task automatic test_wrap();
        apply_reset();
        reserve = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++;
            if (collision !== 1'b0) begin n_err++; $display("FAIL wrap_early%0d got %0b want 0", i, collision); end
        end
        tick();
        n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL wrap_coll got %0b want 1", collision); end
        idle(); read_en = 1;
        #1;
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL wrap_halt got %0b want 1", halt); end
        n_cmp++; if (pending_any !== 2'b01) begin n_err++; $display("FAIL wrap_pend got %0b want 01", pending_any); end
        rst_n = 0;
        model_reset();
        #1;
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL midrst_halt got %0b want 1", halt); end
        n_cmp++; if (pending_any !== 2'b00) begin n_err++; $display("FAIL midrst_pend got %0b want 00", pending_any); end
        n_cmp++; if (collision !== 1'b0) begin n_err++; $display("FAIL midrst_coll got %0b want 0", collision); end
        n_cmp++; if (reserve_slot !== 4'd15) begin n_err++; $display("FAIL midrst_rslot got %0d want 15", reserve_slot); end
        n_cmp++; if (read_value !== 32'h0) begin n_err++; $display("FAIL midrst_value got %0h want 0", read_value); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cv = 2'b01; cslot = {4'd0, 4'd15}; cval = {32'h0, 32'h5A};
        tick();
        cv = '0; read_offset = 4'd15;
        #1;
        n_cmp++; if (collision !== 1'b1) begin n_err++; $display("FAIL stale_coll got %0b want 1", collision); end
        n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL stale_halt got %0b want 1", halt); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 400; it++) begin
            bit [N-1:0] rs;
            bit [F-1:0] ef;
            bit [C-1:0] ep;
            ctx = 1'($urandom_range(0, 1));
            read_en = 1'($urandom_range(0, 1));
            read_offset = 4'($urandom);
            push = ($urandom % 4) == 0;
            reserve = ($urandom % 3) == 0;
            svc = ($urandom % 6) == 0;
            svc_ctx = 1'($urandom_range(0, 1));
            push_value = $urandom; svc_value = $urandom; svc_bus = $urandom;
            for (int p = 0; p < P; p++) begin
                bit [CW-1:0] c;
                c = 1'($urandom_range(0, 1));
                cv[p] = 1'($urandom_range(0, 1));
                cctx[p*CW +: CW] = c;
                cslot[p*N +: N] = ($urandom % 4 != 0) ? mh[c] + 4'($urandom_range(0, 3))
                                                       : 4'($urandom);
                cfault[p*F +: F] = 3'($urandom);
                cval[p*W +: W] = $urandom;
            end
            #1;
            rs = mh[ctx] + read_offset;
            ef = (read_en && m[ctx][rs].fin) ? m[ctx][rs].flt : '0;
            n_cmp++;
            if (halt !== (read_en && !m[ctx][rs].fin)) begin
                n_err++; $display("FAIL rnd_halt it=%0d got %0b want %0b", it, halt,
                                  read_en && !m[ctx][rs].fin);
            end
            n_cmp++;
            if (fault !== ef) begin n_err++; $display("FAIL rnd_fault it=%0d got %0d want %0d", it, fault, ef); end
            n_cmp++;
            if (read_value !== m[ctx][rs].val) begin
                n_err++; $display("FAIL rnd_value it=%0d got %0h want %0h", it, read_value, m[ctx][rs].val);
            end
            n_cmp++;
            if (reserve_slot !== mh[ctx] - 4'd1) begin
                n_err++; $display("FAIL rnd_rslot it=%0d got %0d want %0d", it, reserve_slot, mh[ctx] - 4'd1);
            end
            n_cmp++;
            if (push_stall !== ((push || reserve) && svc && svc_ctx == ctx)) begin
                n_err++; $display("FAIL rnd_stall it=%0d got %0b", it, push_stall);
            end
            tick();
            ep = '0;
            for (int c = 0; c < C; c++) for (int s = 0; s < D; s++) if (m[c][s].pend) ep[c] = 1;
            n_cmp++;
            if (collision !== m_coll) begin n_err++; $display("FAIL rnd_coll it=%0d got %0b want %0b", it, collision, m_coll); end
            n_cmp++;
            if (pending_any !== ep) begin n_err++; $display("FAIL rnd_pend it=%0d got %0b want %0b", it, pending_any, ep); end
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_push_read();
        test_reserve_complete();
        test_svc_cross();
        test_svc_same();
        test_dual_complete();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
